// File: rtl/cnn_window_buffer_if.sv
// Pixel-in / window-out bundle for the CNN window buffer.
// CNN_WIN_COORD_EN adds the window centre coordinate outputs.
interface cnn_window_buffer_if #(
  parameter int MAX_PIXEL_BITS = 8,
  parameter int IMG_WIDTH      = 16,
  parameter int IMG_HEIGHT     = 16
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic                        px_rdy_i;
  logic [MAX_PIXEL_BITS-1:0]   in_px_i;
  logic [9*MAX_PIXEL_BITS-1:0] window_o;
  logic                        window_valid_o;
  logic                        frame_done_o;
  logic                        busy_o;
`ifdef CNN_WIN_COORD_EN
  logic [CW-1:0]               win_col_o;
  logic [RW-1:0]               win_row_o;

  modport slave (
    input  px_rdy_i, in_px_i,
    output window_o, window_valid_o,
    output frame_done_o, busy_o,
    output win_col_o, win_row_o
  );
  modport master (
    output px_rdy_i, in_px_i,
    input  window_o, window_valid_o,
    input  frame_done_o, busy_o,
    input  win_col_o, win_row_o
  );
`else
  modport slave (
    input  px_rdy_i, in_px_i,
    output window_o, window_valid_o,
    output frame_done_o, busy_o
  );
  modport master (
    output px_rdy_i, in_px_i,
    input  window_o, window_valid_o,
    input  frame_done_o, busy_o
  );
`endif
endinterface

// File: rtl/cnn_window_buffer.sv
// 3x3 sliding window over a raster pixel stream using two line buffers.
// Optional CNN_WIN_COORD_EN emits the window centre (col-1,row-1).
module cnn_window_buffer #(
  parameter int MAX_PIXEL_BITS = 8,
  parameter int IMG_WIDTH      = 16,
  parameter int IMG_HEIGHT     = 16
) (
  input logic                clk_i,
  input logic                reset_i,
  input logic                clear_i,
  cnn_window_buffer_if.slave bus
);
  localparam int W  = MAX_PIXEL_BITS;
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic          rst;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [W-1:0]  lb1_q [IMG_WIDTH];
  logic [W-1:0]  lb1_d [IMG_WIDTH];
  logic [W-1:0]  lb2_q [IMG_WIDTH];
  logic [W-1:0]  lb2_d [IMG_WIDTH];
  logic [W-1:0]  win_q [9];
  logic [W-1:0]  win_d [9];
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          col_end, row_end, last;
`ifdef CNN_WIN_COORD_EN
  logic [CW-1:0] wcol_q, wcol_d;
  logic [RW-1:0] wrow_q, wrow_d;
`endif

  assign rst     = reset_i | clear_i;
  assign col_end = (col_q == COL_LAST);
  assign row_end = (row_q == ROW_LAST);
  assign last    = col_end & row_end;

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    lb1_d   = lb1_q;
    lb2_d   = lb2_q;
    win_d   = win_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    busy_d  = busy_q;
`ifdef CNN_WIN_COORD_EN
    wcol_d  = wcol_q;
    wrow_d  = wrow_q;
`endif
    if (bus.px_rdy_i) begin
      col_d = col_end ? '0 : col_q + 1'b1;
      if (col_end)
        row_d = row_end ? '0 : row_q + 1'b1;
      // new right column uses line-buffer contents before this write
      lb2_d[col_q] = lb1_q[col_q];
      lb1_d[col_q] = bus.in_px_i;
      for (int r = 0; r < 3; r++) begin
        win_d[3*r]   = win_q[3*r+1];
        win_d[3*r+1] = win_q[3*r+2];
      end
      win_d[2] = lb2_q[col_q];
      win_d[5] = lb1_q[col_q];
      win_d[8] = bus.in_px_i;
      valid_d  = (col_q >= CW'(2)) && (row_q >= RW'(2));
      done_d   = last;
      busy_d   = ~last;
`ifdef CNN_WIN_COORD_EN
      wcol_d   = col_q - 1'b1;
      wrow_d   = row_q - 1'b1;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      for (int i = 0; i < IMG_WIDTH; i++) begin
        lb1_q[i] <= '0;
        lb2_q[i] <= '0;
      end
      for (int k = 0; k < 9; k++)
        win_q[k] <= '0;
`ifdef CNN_WIN_COORD_EN
      wcol_q  <= '0;
      wrow_q  <= '0;
`endif
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      lb1_q   <= lb1_d;
      lb2_q   <= lb2_d;
      win_q   <= win_d;
`ifdef CNN_WIN_COORD_EN
      wcol_q  <= wcol_d;
      wrow_q  <= wrow_d;
`endif
    end
  end

  for (genvar k = 0; k < 9; k++) begin : g_pack
    assign bus.window_o[k*W +: W] = win_q[k];
  end

  assign bus.window_valid_o = valid_q;
  assign bus.frame_done_o   = done_q;
  assign bus.busy_o         = busy_q;
`ifdef CNN_WIN_COORD_EN
  assign bus.win_col_o      = wcol_q;
  assign bus.win_row_o      = wrow_q;
`endif
endmodule

// File: tb/tb_cnn_window_buffer.sv
// Directed + randomized bench for cnn_window_buffer on a 4x4 image.
// Reference model keeps the frame as a 2D image and slices windows from it.
module tb_cnn_window_buffer;
  localparam int W  = 8;
  localparam int IW = 4;
  localparam int IH = 4;

  logic clk = 1'b0;
  logic reset_i;
  logic clear_i;

  always #5 clk = ~clk;

  cnn_window_buffer_if #(
    .MAX_PIXEL_BITS(W), .IMG_WIDTH(IW), .IMG_HEIGHT(IH)
  ) bus ();

  cnn_window_buffer #(
    .MAX_PIXEL_BITS(W), .IMG_WIDTH(IW), .IMG_HEIGHT(IH)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset_i),
    .clear_i(clear_i),
    .bus    (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  int             p;
  logic [W-1:0]   img [IH][IW];
  logic [9*W-1:0] exp_win;
  bit             win_known;
  bit             exp_busy;
  int             exp_c;
  int             exp_r;

  task automatic chk(string tag, logic [9*W-1:0] obs,
                     logic [9*W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle();
    chk("idle_valid", 72'(bus.window_valid_o), 72'd0);
    chk("idle_done", 72'(bus.frame_done_o), 72'd0);
    chk("idle_busy", 72'(bus.busy_o), 72'(exp_busy));
    if (win_known)
      chk("idle_hold", bus.window_o, exp_win);
  endtask

  // one clock with given inputs, then idle clocks
  task automatic cycle(bit rdy, logic [W-1:0] v,
                       bit rst, bit clr, int idle);
    bit ev;
    bit ed;
    int c;
    int r;
    ev = 1'b0;
    ed = 1'b0;
    bus.px_rdy_i = rdy;
    bus.in_px_i  = v;
    reset_i      = rst;
    clear_i      = clr;
    @(posedge clk);
    #1;
    bus.px_rdy_i = 1'b0;
    reset_i      = 1'b0;
    clear_i      = 1'b0;
    if (rst || clr) begin
      p         = 0;
      exp_busy  = 1'b0;
      exp_win   = '0;
      win_known = 1'b1;
      exp_c     = 0;
      exp_r     = 0;
    end else if (rdy) begin
      c = p % IW;
      r = p / IW;
      img[r][c] = v;
      ev = (c >= 2) && (r >= 2);
      ed = (p == IW*IH - 1);
      p = ed ? 0 : p + 1;
      exp_busy = !ed;
      win_known = ev;
      if (ev) begin
        for (int rr = 0; rr < 3; rr++)
          for (int cc = 0; cc < 3; cc++)
            exp_win[(3*rr+cc)*W +: W] = img[r-2+rr][c-2+cc];
        exp_c = c - 1;
        exp_r = r - 1;
      end
    end
    chk("valid", 72'(bus.window_valid_o), 72'(ev));
    chk("done", 72'(bus.frame_done_o), 72'(ed));
    chk("busy", 72'(bus.busy_o), 72'(exp_busy));
    if (win_known)
      chk("window", bus.window_o, exp_win);
`ifdef CNN_WIN_COORD_EN
    if (win_known) begin
      chk("win_col", 72'(bus.win_col_o), 72'(exp_c));
      chk("win_row", 72'(bus.win_row_o), 72'(exp_r));
    end
`endif
    for (int i = 0; i < idle; i++) begin
      @(posedge clk);
      #1;
      check_idle();
    end
  endtask

  initial begin
    logic [9*W-1:0] first_a;
    logic [9*W-1:0] first_b;
    logic [9*W-1:0] first_c;
    first_a = {8'd10, 8'd9, 8'd8, 8'd6, 8'd5,
               8'd4, 8'd2, 8'd1, 8'd0};
    first_b = {8'd26, 8'd25, 8'd24, 8'd22, 8'd21,
               8'd20, 8'd18, 8'd17, 8'd16};
    first_c = {8'd110, 8'd109, 8'd108, 8'd106, 8'd105,
               8'd104, 8'd102, 8'd101, 8'd100};
    bus.px_rdy_i = 1'b0;
    bus.in_px_i  = '0;
    reset_i      = 1'b0;
    clear_i      = 1'b0;
    p            = 0;
    exp_win      = '0;
    win_known    = 1'b0;
    exp_busy     = 1'b0;
    exp_c        = 0;
    exp_r        = 0;

    cycle(1'b0, '0, 1'b1, 1'b0, 0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1);

    // frame 0..15 back to back, then 16..31 immediately
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, W'(i), 1'b0, 1'b0, 0);
      if (i == 10)
        chk("first_win_a", bus.window_o, first_a);
    end
    for (int i = 16; i < 32; i++) begin
      cycle(1'b1, W'(i), 1'b0, 1'b0, 0);
      if (i == 26)
        chk("first_win_b", bus.window_o, first_b);
    end

    // same stream with 3 idle cycles between pixels
    for (int i = 0; i < 16; i++)
      cycle(1'b1, W'(i), 1'b0, 1'b0, 3);

    // clear coincident with pixel 7, then 100..115
    for (int i = 0; i < 7; i++)
      cycle(1'b1, W'(i), 1'b0, 1'b0, 0);
    cycle(1'b1, 8'd7, 1'b0, 1'b1, 0);
    for (int i = 100; i < 116; i++) begin
      cycle(1'b1, W'(i), 1'b0, 1'b0, 0);
      if (i == 110)
        chk("first_win_c", bus.window_o, first_c);
    end

    // reset for 2 cycles mid-frame, outputs stay 0 while idle
    for (int i = 0; i < 9; i++)
      cycle(1'b1, W'(50 + i), 1'b0, 1'b0, 0);
    cycle(1'b0, '0, 1'b1, 1'b0, 0);
    cycle(1'b0, '0, 1'b1, 1'b0, 3);
    chk("rst_window", bus.window_o, 72'd0);

    // randomized frames with random gaps and occasional clear
    for (int n = 0; n < 200; n++) begin
      bit clr;
      clr = ($urandom_range(0, 60) == 0);
      cycle(1'b1, W'($urandom), 1'b0, clr,
            int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
